player_mover: RTL and testbench
===============================

PLAYER_MOVER -- requirements
Module: player_mover

Interface
REQ-001 Parameter NPLAYERS, 2: number of players, range 1..4.
REQ-002 Parameter W, 11: signed coordinate width.
REQ-003 Parameter DIV, 2048: clock cycles per movement tick, at least 2.
REQ-004 Parameter STEP, 1: pixels moved per tick, at least 1.
REQ-005 Parameters X_MIN/X_MAX/Y_MIN/Y_MAX, 32/767/32/567: inclusive play-area bounds.
REQ-006 Parameter CELL, 32: grid cell size, power of 2; used only by GRID_SNAP_EN.
REQ-007 clk  in  1  system clock.
REQ-008 reset_n  in  1  asynchronous, active-low reset.
REQ-009 SOF  in  1  start-of-frame pulse; closes the update window.
REQ-010 EOF  in  1  end-of-frame pulse; opens the update window.
REQ-011 load  in  1  synchronous reload of all players to their start corners.
REQ-012 key  in  4*NPLAYERS  active-low keys; nibble i belongs to player i: bit0 right, bit1 down, bit2 up, bit3 left.
REQ-013 pos_x  out  W*NPLAYERS  signed X per player; slice i belongs to player i.
REQ-014 pos_y  out  W*NPLAYERS  signed Y per player.
REQ-015 moved  out  NPLAYERS  one-cycle pulse: player i's position changed this cycle.
REQ-016 frame_open  out  1  high while the update window is open.

Function
REQ-017 Window FSM has two states, LOCKED and OPEN. LOCKED->OPEN on EOF; OPEN->LOCKED on SOF. If EOF and SOF are high in the same cycle, EOF wins and the next state is OPEN. frame_open = (state==OPEN), registered.
REQ-018 Tick counter cnt, width clog2(DIV): cleared to 0 on the cycle EOF is sampled; increments every OPEN cycle; wraps from DIV-1 to 0. tick = OPEN and cnt==DIV-1. cnt holds while LOCKED.
REQ-019 On tick, each player whose nibble has exactly one bit low moves STEP in that direction. Zero or more than one low bit means no move.
REQ-020 Arithmetic uses W+1 bits. A result beyond a bound clamps to the bound. A player already at the bound does not move and gets no moved pulse.
REQ-021 Positions and moved update on the clock edge after the tick cycle. moved[i] is high for exactly that one cycle and only if pos_x or pos_y actually changed.
REQ-022 Players are fully independent. No collision checking between players.
REQ-023 Start corners: P0 (X_MIN,Y_MIN), P1 (X_MAX,Y_MAX), P2 (X_MAX,Y_MIN), P3 (X_MIN,Y_MAX).
REQ-024 load takes priority over tick. When load is high, all positions go to their start corners, moved stays 0, and the FSM and cnt are unaffected.
REQ-025 Key changes while LOCKED have no effect. Only the key value sampled on the tick cycle matters.

Reset
REQ-026 reset_n low asynchronously forces: state LOCKED, cnt 0, moved 0, frame_open 0, all positions to their start corners.
REQ-027 Reset in the middle of a window aborts any pending move. After release, no move occurs until the next EOF.

Configuration
REQ-028 Macro GRID_SNAP_EN, when defined: a horizontal move is allowed only if (pos_y - Y_MIN) mod CELL == 0; a vertical move is allowed only if (pos_x - X_MIN) mod CELL == 0. A blocked move produces no change and no moved pulse.
REQ-029 Macro GRID_SNAP_EN, when undefined: no alignment restriction. CELL is ignored and no alignment logic is synthesised.

Verification
Bench uses DIV=4, STEP=1, NPLAYERS=2, other parameters at defaults.
REQ-030 Reset, then EOF pulse, then key=8'hFE held -> P0 x goes 32->33 one cycle after the 4th OPEN cycle, moved=2'b01 for 1 cycle; P1 stays at (767,567).
REQ-031 P1 at (767,567), P1 nibble 4'b1110, 8 OPEN cycles -> P1 x stays 767 and moved[1] never asserts.
REQ-032 P0 nibble 4'b1100 (two keys low) over 2 ticks -> no move, moved=0.
REQ-033 EOF and SOF in the same cycle -> frame_open=1 next cycle. A later SOF -> frame_open=0, and cnt holds its value until the next EOF, which clears it.
REQ-034 load high in the same cycle as a tick with P0 at (40,32) -> P0 at (32,32), moved=0.
REQ-035 With GRID_SNAP_EN defined, P0 at (32,33), right key held -> no X change. Up key -> y goes to 32; after that, right key -> x goes to 33.

Source files
------------

// File: rtl/player_mover.sv
// Frame-gated movement of up to four players on a clamped play area, stepping on a divided tick.
// Optional macro GRID_SNAP_EN restricts moves to the grid lines of a CELL-sized lattice.
module player_mover #(
  parameter int NPLAYERS = 2,
  parameter int W        = 11,
  parameter int DIV      = 2048,
  parameter int STEP     = 1,
  parameter int X_MIN    = 32,
  parameter int X_MAX    = 767,
  parameter int Y_MIN    = 32,
  parameter int Y_MAX    = 567,
  parameter int CELL     = 32
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    SOF,
  input  logic                    EOF,
  input  logic                    load,
  input  logic [4*NPLAYERS-1:0]   key,
  output logic [W*NPLAYERS-1:0]   pos_x,
  output logic [W*NPLAYERS-1:0]   pos_y,
  output logic [NPLAYERS-1:0]     moved,
  output logic                    frame_open
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]       CNT_LAST = CW'(DIV - 1);
  localparam logic signed [W:0]   STEP_W   = (W+1)'(STEP);
  localparam logic signed [W:0]   XMIN_W   = (W+1)'(X_MIN);
  localparam logic signed [W:0]   XMAX_W   = (W+1)'(X_MAX);
  localparam logic signed [W:0]   YMIN_W   = (W+1)'(Y_MIN);
  localparam logic signed [W:0]   YMAX_W   = (W+1)'(Y_MAX);

  if ((CELL < 1) || ((CELL & (CELL - 1)) != 0)) begin : g_bad_cell
    $error("player_mover: CELL must be a power of two");
  end

  typedef enum logic {LOCKED, OPEN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] cnt;
  logic          tick;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= LOCKED;
    else          state <= state_next;
  end

  // EOF dominates a coincident SOF so the window still opens.
  always_comb begin
    state_next = state;
    if (EOF)      state_next = OPEN;
    else if (SOF) state_next = LOCKED;
  end

  always_comb begin
    frame_open = (state == OPEN);
    tick       = (state == OPEN) && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)            cnt <= '0;
    else if (EOF)            cnt <= '0;
    else if (state == OPEN)  cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
  end

  for (genvar i = 0; i < NPLAYERS; i++) begin : g_player
    localparam logic signed [W-1:0] X0 = ((i == 1) || (i == 2)) ? W'(X_MAX) : W'(X_MIN);
    localparam logic signed [W-1:0] Y0 = ((i == 1) || (i == 3)) ? W'(Y_MAX) : W'(Y_MIN);

    logic signed [W-1:0] px, py;
    logic signed [W:0]   cur_x, cur_y, cand_x, cand_y, nx, ny;
    logic [3:0]          nib;
    logic                allow, change, mv;

    assign nib   = key[4*i +: 4];
    assign cur_x = {px[W-1], px};
    assign cur_y = {py[W-1], py};

    // Only a single pressed key (one low bit) produces a candidate step.
    always_comb begin
      cand_x = cur_x;
      cand_y = cur_y;
      case (nib)
        4'b1110: cand_x = cur_x + STEP_W;
        4'b1101: cand_y = cur_y + STEP_W;
        4'b1011: cand_y = cur_y - STEP_W;
        4'b0111: cand_x = cur_x - STEP_W;
        default: ;
      endcase
    end

`ifdef GRID_SNAP_EN
    localparam logic [W-1:0] CMASK = W'(CELL - 1);
    logic [W-1:0] off_x, off_y;
    assign off_x = px - W'(X_MIN);
    assign off_y = py - W'(Y_MIN);
    assign allow = ((nib == 4'b1110) || (nib == 4'b0111)) ? ((off_y & CMASK) == '0) :
                   ((nib == 4'b1101) || (nib == 4'b1011)) ? ((off_x & CMASK) == '0) : 1'b1;
`else
    assign allow = 1'b1;
`endif

    always_comb begin
      nx = cur_x;
      ny = cur_y;
      if (allow) begin
        if (cand_x > XMAX_W)      nx = XMAX_W;
        else if (cand_x < XMIN_W) nx = XMIN_W;
        else                      nx = cand_x;
        if (cand_y > YMAX_W)      ny = YMAX_W;
        else if (cand_y < YMIN_W) ny = YMIN_W;
        else                      ny = cand_y;
      end
      change = (nx != cur_x) || (ny != cur_y);
    end

    // load wins over a coincident tick and never raises moved.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        px <= X0;
        py <= Y0;
        mv <= 1'b0;
      end else if (load) begin
        px <= X0;
        py <= Y0;
        mv <= 1'b0;
      end else if (tick && change) begin
        px <= nx[W-1:0];
        py <= ny[W-1:0];
        mv <= 1'b1;
      end else begin
        mv <= 1'b0;
      end
    end

    assign pos_x[W*i +: W] = px;
    assign pos_y[W*i +: W] = py;
    assign moved[i]        = mv;
  end

endmodule

// File: tb/tb_player_mover.sv
// Directed, table-driven bench for player_mover with DIV=4, STEP=1, two players.
// Also exercises the GRID_SNAP_EN variant when that macro is defined for the build.
module tb_player_mover;
  localparam int NP = 2;
  localparam int W  = 11;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              sof = 1'b0, eof = 1'b0, load = 1'b0;
  logic [4*NP-1:0]   key = 8'hFF;
  logic [W*NP-1:0]   pos_x, pos_y;
  logic [NP-1:0]     moved;
  logic              frame_open;
  int                total = 0;
  int                bad = 0;

  typedef struct {
    logic       sof, eof, ld;
    logic [7:0] key;
    int         x0, y0, x1, y1;
    logic [1:0] mv;
    logic       op;
  } vec_t;

  vec_t vecs[$];

  player_mover #(.NPLAYERS(NP), .W(W), .DIV(4), .STEP(1)) dut (
    .clk(clk), .reset_n(reset_n), .SOF(sof), .EOF(eof), .load(load), .key(key),
    .pos_x(pos_x), .pos_y(pos_y), .moved(moved), .frame_open(frame_open)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void add(input logic s, input logic e, input logic l, input logic [7:0] k,
                              input int x0, input int y0, input int x1, input int y1,
                              input logic [1:0] mv, input logic op);
    vec_t v;
    v.sof = s; v.eof = e; v.ld = l; v.key = k;
    v.x0 = x0; v.y0 = y0; v.x1 = x1; v.y1 = y1; v.mv = mv; v.op = op;
    vecs.push_back(v);
  endfunction

  function automatic int get_x(input int i);
    return int'($signed(pos_x[W*i +: W]));
  endfunction

  function automatic int get_y(input int i);
    return int'($signed(pos_y[W*i +: W]));
  endfunction

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string tag, input int x0, input int y0, input int x1,
                             input int y1, input logic [1:0] mv, input logic op);
    check_output({tag, " x0"}, get_x(0), x0);
    check_output({tag, " y0"}, get_y(0), y0);
    check_output({tag, " x1"}, get_x(1), x1);
    check_output({tag, " y1"}, get_y(1), y1);
    check_output({tag, " moved"}, int'(moved), int'(mv));
    check_output({tag, " frame_open"}, int'(frame_open), int'(op));
  endtask

  task automatic apply_stimulus(input logic s, input logic e, input logic l, input logic [7:0] k);
    @(negedge clk);
    sof = s; eof = e; load = l; key = k;
    @(posedge clk);
    #1;
  endtask

  // Three quiet cycles then the tick cycle; assumes the counter is at 0 on entry.
  task automatic do_tick(input string tag, input logic [7:0] k, input int x0, input int y0,
                         input int x1, input int y1, input logic [1:0] mv);
    repeat (3) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, k);
      check_output({tag, " pre-tick moved"}, int'(moved), 0);
    end
    apply_stimulus(1'b0, 1'b0, 1'b0, k);
    check_state(tag, x0, y0, x1, y1, mv, 1'b1);
  endtask

  initial begin
    int ex, ey;
    logic [7:0] k;

    add(0, 0, 0, 8'hFF, 32, 32, 767, 567, 2'b00, 0);
    add(0, 1, 0, 8'hFE, 32, 32, 767, 567, 2'b00, 1);
    repeat (3) add(0, 0, 0, 8'hFE, 32, 32, 767, 567, 2'b00, 1);
    add(0, 0, 0, 8'hFE, 33, 32, 767, 567, 2'b01, 1);
    repeat (8) add(0, 0, 0, 8'hEF, 33, 32, 767, 567, 2'b00, 1);
    repeat (8) add(0, 0, 0, 8'hDC, 33, 32, 767, 567, 2'b00, 1);
    repeat (3) add(0, 0, 0, 8'h7D, 33, 32, 767, 567, 2'b00, 1);
    add(0, 0, 0, 8'h7D, 33, 33, 766, 567, 2'b11, 1);
    add(0, 0, 0, 8'hFF, 33, 33, 766, 567, 2'b00, 1);
    add(1, 0, 0, 8'hFF, 33, 33, 766, 567, 2'b00, 0);
    repeat (4) add(0, 0, 0, 8'h7D, 33, 33, 766, 567, 2'b00, 0);
    add(1, 1, 0, 8'h7D, 33, 33, 766, 567, 2'b00, 1);
    repeat (3) add(0, 0, 0, 8'h7D, 33, 33, 766, 567, 2'b00, 1);
    add(0, 0, 0, 8'h7D, 33, 34, 765, 567, 2'b11, 1);
    add(1, 0, 0, 8'hFF, 33, 34, 765, 567, 2'b00, 0);

    #12;
    check_state("in reset", 32, 32, 767, 567, 2'b00, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    for (int n = 0; n < vecs.size(); n++) begin
      apply_stimulus(vecs[n].sof, vecs[n].eof, vecs[n].ld, vecs[n].key);
      check_state($sformatf("vec%0d", n), vecs[n].x0, vecs[n].y0, vecs[n].x1, vecs[n].y1,
                  vecs[n].mv, vecs[n].op);
    end

    // Walk P0 to (40,32), then assert load on the tick cycle.
    ex = 33; ey = 34;
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hFE);
    check_state("load-setup eof", ex, ey, 765, 567, 2'b00, 1'b1);
    for (int t = 0; t < 9; t++) begin
      k = (t < 2) ? 8'hFB : 8'hFE;
      if (t < 2) ey = (ey - 1 < 32) ? 32 : ey - 1;
      else       ex = (ex + 1 > 767) ? 767 : ex + 1;
      do_tick($sformatf("walk%0d", t), k, ex, ey, 765, 567, 2'b01);
    end
    check_output("walk end x0", get_x(0), 40);
    repeat (3) apply_stimulus(1'b0, 1'b0, 1'b0, 8'hFE);
    apply_stimulus(1'b0, 1'b0, 1'b1, 8'hFE);
    check_state("load on tick", 32, 32, 767, 567, 2'b00, 1'b1);
    do_tick("after load", 8'hFE, 33, 32, 767, 567, 2'b01);

    // Reset mid-window must abort the pending move and keep the window shut.
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'hFE);
    apply_stimulus(1'b0, 1'b0, 1'b0, 8'hFE);
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check_state("async reset", 32, 32, 767, 567, 2'b00, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      apply_stimulus(1'b0, 1'b0, 1'b0, 8'hFE);
      check_output($sformatf("post-reset moved c%0d", c), int'(moved), 0);
    end
    check_state("post-reset idle", 32, 32, 767, 567, 2'b00, 1'b0);
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hFE);
    do_tick("post-reset eof", 8'hFE, 33, 32, 767, 567, 2'b01);

    // Misaligned row: P0 at (32,33) trying to go right.
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    apply_stimulus(1'b0, 1'b1, 1'b0, 8'hFF);
    check_output("grid eof open", int'(frame_open), 1);
    do_tick("grid down", 8'hFD, 32, 33, 767, 567, 2'b01);
`ifdef GRID_SNAP_EN
    do_tick("grid right blocked", 8'hFE, 32, 33, 767, 567, 2'b00);
    do_tick("grid up", 8'hFB, 32, 32, 767, 567, 2'b01);
    do_tick("grid right ok", 8'hFE, 33, 32, 767, 567, 2'b01);
`else
    do_tick("free right", 8'hFE, 33, 33, 767, 567, 2'b01);
    do_tick("free up", 8'hFB, 33, 32, 767, 567, 2'b01);
    do_tick("free right 2", 8'hFE, 34, 32, 767, 567, 2'b01);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
